// File: rtl/time_entry.sv
// time_entry: digit-serial time-setting front end for the RTC.
// Accepts four BCD digits (H1, H0, M1, M0), one per digit_valid_i strobe.
// Each digit is range-checked as it arrives. The completed entry is
// converted to binary, then loaded into the RTC with a one-cycle pulse.
//
// Ports:
//   clk                 system clock, rising-edge active
//   rst                 asynchronous active-high reset
//   digit_i[3:0]        BCD digit being entered
//   digit_valid_i       one digit per high cycle
//   clear_i             synchronous abort; discards a partial entry or a pending load
//   initial_time_hh     binary hours 0..23, held until the next load
//   initial_time_mm     binary minutes 0..59, held until the next load
//   initial_time_valid  one-cycle load pulse to the RTC
//   entry_busy          high while converting; digits are ignored then
//   digit_idx[1:0]      next digit expected: 0=H1, 1=H0, 2=M1, 3=M0
//   err                 one-cycle pulse after a rejected digit
module time_entry (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_i,
  input  logic       digit_valid_i,
  input  logic       clear_i,
  output logic [4:0] initial_time_hh,
  output logic [5:0] initial_time_mm,
  output logic       initial_time_valid,
  output logic       entry_busy,
  output logic [1:0] digit_idx,
  output logic       err
);

  typedef enum logic [2:0] {
    S_H1   = 3'd0,
    S_H0   = 3'd1,
    S_M1   = 3'd2,
    S_M0   = 3'd3,
    S_CONV = 3'd4
  } state_e;

  state_e     state;
  logic [3:0] h1, h0, m1, m0;

  // BCD to binary: x*10 = (x<<3) + (x<<1), computed wide, then truncated.
  logic [6:0] hh_full, mm_full;
  assign hh_full = ({3'b000, h1} << 3) + ({3'b000, h1} << 1) + {3'b000, h0};
  assign mm_full = ({3'b000, m1} << 3) + ({3'b000, m1} << 1) + {3'b000, m0};

  // Hours may only reach 23, so H0 is capped at 3 when H1 is 2.
  logic h0_ok;
  assign h0_ok = (digit_i <= 4'd9) && !((h1 == 4'd2) && (digit_i > 4'd3));

  assign entry_busy = (state == S_CONV);
  // S_CONV reads as 3 (the last digit position); the other states map directly.
  assign digit_idx  = (state == S_CONV) ? 2'd3 : state[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_H1;
      h1                 <= 4'd0;
      h0                 <= 4'd0;
      m1                 <= 4'd0;
      m0                 <= 4'd0;
      initial_time_hh    <= 5'd0;
      initial_time_mm    <= 6'd0;
      initial_time_valid <= 1'b0;
      err                <= 1'b0;
    end else begin
      initial_time_valid <= 1'b0;
      err                <= 1'b0;
      if (clear_i) begin
        // Abort wins over any strobe; a pending load in S_CONV is dropped.
        state <= S_H1;
        h1    <= 4'd0;
        h0    <= 4'd0;
        m1    <= 4'd0;
        m0    <= 4'd0;
      end else begin
        unique case (state)
          S_H1: begin
            if (digit_valid_i) begin
              if (digit_i <= 4'd2) begin
                h1    <= digit_i;
                state <= S_H0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_H0: begin
            if (digit_valid_i) begin
              if (h0_ok) begin
                h0    <= digit_i;
                state <= S_M1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_M1: begin
            if (digit_valid_i) begin
              if (digit_i <= 4'd5) begin
                m1    <= digit_i;
                state <= S_M0;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_M0: begin
            if (digit_valid_i) begin
              if (digit_i <= 4'd9) begin
                m0    <= digit_i;
                state <= S_CONV;
              end else begin
                err <= 1'b1;
              end
            end
          end
          S_CONV: begin
            // Strobes here are dropped silently.
            initial_time_hh    <= hh_full[4:0];
            initial_time_mm    <= mm_full[5:0];
            initial_time_valid <= 1'b1;
            state              <= S_H1;
          end
          default: state <= S_H1;
        endcase
      end
    end
  end

endmodule
